// File: rtl/cpu_rp2a03_apu_envelope_bank.sv
// Multi-channel RP2A03 envelope generator bank.
// One instance serves every envelope-driven channel. Each channel keeps a start
// flag, a divider and a decay level, advanced by the shared quarter-frame tick.
// Optional feature macro: APU_ENVELOPE_DONE_STATUS_EN adds envelope_done_o, a
// registered per-channel "decayed to silence and will stay there" flag.
module cpu_rp2a03_apu_envelope_bank #(
  parameter int unsigned CH_NUM = 3,
  parameter int unsigned VOL_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CH_NUM-1:0]       length_counter_load_reg_wr_i,
  input  logic                    quarter_frame_i,
  input  logic [CH_NUM-1:0]       chan_en_i,
  input  logic [CH_NUM-1:0]       const_volume_i,
  input  logic [CH_NUM-1:0]       envelope_loop_i,
  input  logic [CH_NUM*VOL_W-1:0] volume_i,
  output logic [CH_NUM*VOL_W-1:0] envelope_level_o
`ifdef APU_ENVELOPE_DONE_STATUS_EN
  ,
  output logic [CH_NUM-1:0]       envelope_done_o
`endif
);

  localparam logic [VOL_W-1:0] DecayMax = '1;
  localparam logic [VOL_W-1:0] One      = VOL_W'(1);

  logic [CH_NUM-1:0]            start_q, start_d;
  logic [CH_NUM-1:0][VOL_W-1:0] div_q, div_d;
  logic [CH_NUM-1:0][VOL_W-1:0] decay_q, decay_d;
  logic [CH_NUM-1:0][VOL_W-1:0] vol;
  logic [CH_NUM-1:0][VOL_W-1:0] level;

  // Packed 2-D view of the flat volume bus: channel k is bits [k*VOL_W +: VOL_W].
  assign vol = volume_i;

  // Next-state for start flag, divider and decay level of every channel.
  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      // A register write wins over a same-cycle tick and is accepted while frozen.
      if (length_counter_load_reg_wr_i[k]) begin
        start_d[k] = 1'b1;
      end else if (quarter_frame_i && chan_en_i[k]) begin
        start_d[k] = 1'b0;
      end

      if (quarter_frame_i && chan_en_i[k]) begin
        if (start_q[k]) begin
          decay_d[k] = DecayMax;
          div_d[k]   = vol[k];
        end else if (div_q[k] == '0) begin
          div_d[k] = vol[k];
          if (decay_q[k] != '0) begin
            decay_d[k] = decay_q[k] - One;
          end else if (envelope_loop_i[k]) begin
            decay_d[k] = DecayMax;
          end
        end else begin
          div_d[k] = div_q[k] - One;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= '0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  // Output mux straight off registered state; constant volume bypasses decay.
  always_comb begin
    level = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (!chan_en_i[k]) begin
        level[k] = '0;
      end else if (const_volume_i[k]) begin
        level[k] = vol[k];
      end else begin
        level[k] = decay_q[k];
      end
    end
  end

  assign envelope_level_o = level;

`ifdef APU_ENVELOPE_DONE_STATUS_EN
  logic [CH_NUM-1:0] done_q, done_d;

  // Channel is silent for good: no loop, no const, no pending start, decay at 0.
  always_comb begin
    done_d = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      done_d[k] = chan_en_i[k] & ~envelope_loop_i[k] & ~const_volume_i[k] &
                  ~start_q[k] & (decay_q[k] == '0);
    end
  end

  // Done status register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

  assign envelope_done_o = done_q;
`endif

endmodule

// File: doc/cpu_rp2a03_apu_envelope_bank.md
Name: cpu_RP2A03_apu_envelope_bank

Overview:
Multi-channel, width-parametrised envelope generator for the RP2A03 audio processor.
- One instance serves every envelope-driven channel (pulse 1, pulse 2, noise, plus expansion channels), replacing per-channel envelope instances.
- Adds synchronous reset of all state, a per-channel enable/freeze, and a parametrised level width.
- Sits between the APU register file and the channel mixers; clocked by the frame sequencer's quarter-frame tick.

Parameters:
CH_NUM, 3, number of envelope channels (1..8)
VOL_W, 4, width of volume, divider and decay level in bits (4..8); decay reload value is all-ones of VOL_W

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
length_counter_load_reg_wr_i  input  CH_NUM  per-channel strobe: write to the channel's length-counter-load register
quarter_frame_i  input  1  quarter-frame tick, one clk wide, shared by all channels
chan_en_i  input  CH_NUM  per-channel enable; 0 freezes the channel's state and mutes its output
const_volume_i  input  CH_NUM  per-channel constant-volume flag
envelope_loop_i  input  CH_NUM  per-channel loop flag
volume_i  input  CH_NUM*VOL_W  packed per-channel volume / divider period; channel k occupies bits [k*VOL_W +: VOL_W]
envelope_level_o  output  CH_NUM*VOL_W  packed per-channel envelope level, same packing

Behaviour:
- Single clock domain (clk_i); rst_i is synchronous, active-high.
- Per-channel state: start flag (1 bit), divider (VOL_W), decay level (VOL_W).
- Reset: start flag, divider and decay level all 0; envelope_level_o = 0 for every channel.
- Start flag, per clock, for channel k:
  - load strobe = 1 -> start flag set to 1. The strobe wins over a simultaneous quarter_frame_i.
  - else quarter_frame_i = 1 and chan_en_i[k] = 1 -> start flag cleared.
  - else hold.
- The load strobe is accepted even when chan_en_i[k] = 0, so the start is pending when the channel is re-enabled.
- On quarter_frame_i = 1 with chan_en_i[k] = 1, using values registered before the edge, in priority order:
  - start flag = 1 -> decay = all-ones; divider = volume.
  - divider = 0 -> divider = volume. Then:
    - decay != 0 -> decay - 1;
    - decay = 0 and loop = 1 -> decay = all-ones (wrap);
    - decay = 0 and loop = 0 -> hold at 0.
  - otherwise -> divider - 1; decay holds.
- With no quarter-frame tick, or chan_en_i[k] = 0: divider and decay hold.
- Output, registered state only (no extra pipeline stage):
  - chan_en_i[k] = 0 -> level = 0;
  - const_volume_i[k] = 1 -> level = volume[k];
  - otherwise -> level = decay[k].
- const_volume_i affects only the output mux; the divider and decay keep running underneath.
- volume_i may change at any time; it is sampled only on a reload event.
- Latency: a state change appears on envelope_level_o one clock after the quarter-frame tick. A load strobe's effect appears after the next enabled quarter-frame tick.
- Channels are fully independent; simultaneous events on different channels have no interaction.
- Reset asserted mid-decay clears the channel; the next quarter-frame sees divider = 0 with start flag = 0, so it reloads the divider and decay stays 0 unless loop = 1.

Optional Feature:
Macro: APU_ENVELOPE_DONE_STATUS_EN
- Defined:
  - Adds output envelope_done_o [CH_NUM], registered, reset to 0.
  - Bit k is high when chan_en_i[k] = 1, loop = 0, const = 0, start flag = 0 and decay = 0, i.e. the channel has decayed to silence and will stay there.
  - Bit k clears on the clock after a load strobe sets the start flag.
  - For use by the mixer to gate idle channels.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, CH_NUM=3, VOL_W=4 -> all levels 0. Load strobe ch0, volume=2, const=0, loop=0, then 1 quarter tick -> ch0 level 15. Every further 3 ticks -> 14, 13 ... 0. After 0 it stays 0 for 10 more cycles.
- Same setup with loop=1 and volume=0 -> levels 15, 14, ..., 0, 15, one step per tick (wraps).
- Load strobe and quarter tick in the same cycle on ch1 -> start flag stays 1, decay unchanged. Next tick -> level 15.
- const=1, volume=9 on ch2 while decaying -> level reads 9 immediately. Drop const after 6 ticks with divider period 0 -> level shows 15-5=10 (underlying decay ran: 15, then 5 decrements).
- chan_en_i[0]=0 for 5 ticks mid-decay at level 12 -> output 0, state frozen. Re-enable -> level 12, decay resumes at the original cadence.
- VOL_W=6 build, volume=1, loop=0 -> start gives 63. Decrements every 2 ticks; reaches 0 after 127 ticks total. With the macro defined, envelope_done_o[0] asserts one cycle after level 0 and drops after the next load strobe.
